paddle_ctrl: RTL and testbench
==============================

# paddle_ctrl

Parametrised successor to the single-object mover inside the game top level. It owns one rectangular paddle on an H_RES×V_RES raster, moves it once per action tick from buttons or the accelerometer with a speed ramp while a direction is held, clamps it to the screen, and drives a per-pixel `obj_draw` flag for the RGB mux. It sits between the SVGA timing counters and the colour output logic, and replaces the hard-coded 800×600 / 100×10 / fixed-speed logic.

## Interface
- `H_RES`, 800: active pixels per line
- `V_RES`, 600: active lines
- `OBJ_W`, 100: paddle width in pixels
- `OBJ_H`, 10: paddle height in lines
- `INIT_H`, 350: reset horizontal coordinate
- `INIT_V`, 500: reset vertical coordinate
- `BASE_SPEED`, 5: pixels per action at multiplier 1
- `MAX_MULT`, 4: saturation value of the speed multiplier (≥1)
- `FRAMES_PER_ACTION`, 2: frames per action tick (≥1)
- `ACCEL_DEADZONE`, 2: |corrected accel| ≤ this means no motion
- `pixel_clk` in 1: pixel clock
- `rst_n` in 1: synchronous reset, active low
- `h_coord` in 11: current pixel column
- `v_coord` in 10: current pixel row
- `mode` in 2: `paddle_pkg::mode_t`; BUTTONS=2'b11, ACCEL=2'b10, other values FROZEN
- `button_l`, `button_r`, `button_u`, `button_d` in 1 each: debounced level inputs
- `accel_x`, `accel_y` in 8: signed two's-complement, already offset-corrected
- `obj_h` out 11: paddle left column, reset `INIT_H`
- `obj_v` out 10: paddle top row, reset `INIT_V`
- `obj_draw` out 1: current pixel is inside the paddle; reset-independent (combinational)
- `moving` out 1: the last action changed `obj_h` or `obj_v`, reset 0
- `mult` out 3: current speed multiplier, reset 1

## Operation
- Frame tick: `eof` is registered high for one cycle when `h_coord==H_RES-1 && v_coord==V_RES-1`. A divider counts `eof` pulses modulo `FRAMES_PER_ACTION`. An action fires on `eof` when the divider equals 0. The divider is 0 at reset, so the first `eof` after reset is an action.
- Direction: per axis the value is NEG, POS or NONE.
  - BUTTONS: l→NEG, r→POS, u→NEG, d→POS.
  - ACCEL: `accel_y` > +DZ → h NEG; `accel_y` < −DZ → h POS; `accel_x` < −DZ → v NEG; `accel_x` > +DZ → v POS.
  - FROZEN: NONE on both axes.
  - Opposing buttons both pressed → NONE on that axis.
- Ramp state per axis: IDLE and RAMP(dir).
  - At an action with dir≠NONE: same dir as the stored state → `mult`=min(`mult`+1, `MAX_MULT`); otherwise `mult`=1 and state becomes RAMP(dir).
  - dir=NONE → state IDLE, `mult`=1.
  - `mult` output is the h-axis multiplier.
  - The step applied at an action uses the multiplier value after that action's update.
- Step is `BASE_SPEED*mult`, computed in 11 bits with no truncation.
- Clamp NEG: coord < step → 0.
- Clamp POS: coord+step+OBJ_W > H_RES−1 → H_RES−1−OBJ_W. The vertical axis uses the same rule with OBJ_H and V_RES.
- `obj_draw` = `obj_h` ≤ h < `obj_h`+OBJ_W and `obj_v` ≤ v < `obj_v`+OBJ_H (half-open).
- A mode change takes effect at the next action. Ramp state is cleared whenever `mode` differs from its value at the previous action.

## Timing
- Pixel (H_RES−1, V_RES−1) at cycle N → `eof` at N+1 → `obj_h`/`obj_v`/`mult`/`moving` update at N+2.
- Inputs are sampled only in the cycle `eof` is high; glitches between actions are ignored.
- `obj_draw` has zero latency relative to `h_coord`/`v_coord`. Coordinates never change during the active area.
- Reset is a synchronous override on every register, including the divider. Reset asserted mid-frame gives `INIT_H`/`INIT_V` on the next edge, and the divider restarts at 0.

## Configuration
- `PADDLE_VERTICAL_EN`
  - Defined: vertical axis moves as described.
  - Undefined: `obj_v` is held at `INIT_V`, u/d buttons and `accel_x` are ignored, and the v-axis ramp logic is not synthesised.

## Structure
- `paddle_pkg` holds:
  - `mode_t` (BUTTONS, ACCEL, FROZEN)
  - `dir_t` (NONE, NEG, POS)
  - `ramp_state_t`
  - the function `clamp_step(coord, step, size, res)`, shared by both axes.
- Sub-module `frame_tick_gen` (params H_RES, V_RES, FRAMES_PER_ACTION) outputs `eof` and `action`. The SVGA top level reuses it.

## Test plan
- Reset, BUTTONS mode, hold `button_l` for 5 actions → `obj_h` 350→345→335→320→300→280; `mult` 1,2,3,4,4.
- `obj_h`=690, hold `button_r` → first action gives `obj_h`=695; second action (step 10) clamps to 699; `moving`=0 on the following action.
- Release the button for one action, then press `button_r` again → `mult` returns to 1 and the first step is 5.
- `button_l` and `button_r` together at `obj_h`=350 for 3 actions → `obj_h` stays 350, `mult`=1.
- ACCEL mode, `accel_y`=+2 → no motion. `accel_y`=+3 → `obj_h` decreases 5, 10, …. `accel_x`=−3 → `obj_v` decreases (with `PADDLE_VERTICAL_EN` defined); with the macro undefined, `obj_v`=500 throughout.
- `FRAMES_PER_ACTION`=3 → moves on `eof` pulses 0, 3, 6 only. `rst_n` pulsed mid-frame → `obj_h`=350 and `obj_v`=500 the next cycle, and the next `eof` is an action.

Source files
------------

// File: rtl/paddle_ctrl_pkg.sv
// paddle_pkg: shared types and helpers for the paddle mover.
//   mode_t       - input source select (BUTTONS, ACCEL, anything else frozen)
//   dir_t        - per-axis motion direction
//   ramp_state_t - per-axis speed ramp state
//   ramp_t       - ramp state plus its speed multiplier
//   clamp_step() - one move along an axis, clamped to the visible raster
//   ramp_update()- one action's update of an axis ramp
package paddle_pkg;

    typedef enum logic [1:0] {
        MODE_FROZEN  = 2'b00,
        MODE_ACCEL   = 2'b10,
        MODE_BUTTONS = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_NEG  = 2'b01,
        DIR_POS  = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        RAMP_IDLE = 2'b00,
        RAMP_NEG  = 2'b01,
        RAMP_POS  = 2'b10
    } ramp_state_t;

    typedef struct packed {
        ramp_state_t st;
        logic [2:0]  mult;
    } ramp_t;

    localparam ramp_t RAMP_RST = '{st: RAMP_IDLE, mult: 3'd1};

    // The far edge is checked in 13 bits so coord+step+size never wraps.
    function automatic logic [10:0] clamp_step(input dir_t dir, input logic [10:0] coord,
                                               input logic [10:0] step, input logic [10:0] size,
                                               input logic [10:0] res);
        logic [12:0] far_edge;
        logic [10:0] nxt;
        far_edge = {2'b00, coord} + {2'b00, step} + {2'b00, size};
        nxt      = coord;
        case (dir)
            DIR_NEG: nxt = (coord < step) ? 11'd0 : coord - step;
            DIR_POS: nxt = (far_edge > ({2'b00, res} - 13'd1)) ? (res - 11'd1 - size) : (coord + step);
            default: nxt = coord;
        endcase
        return nxt;
    endfunction

    // clear forces a restart of the ramp even if the direction is unchanged
    // (used when the input mode changed since the previous action).
    function automatic ramp_t ramp_update(input ramp_t cur, input dir_t dir, input logic clear,
                                          input logic [2:0] max_mult);
        ramp_t       nxt;
        ramp_state_t want;
        want = (dir == DIR_NEG) ? RAMP_NEG : RAMP_POS;
        nxt  = RAMP_RST;
        if (dir != DIR_NONE) begin
            nxt.st = want;
            if (!clear && (cur.st == want)) begin
                nxt.mult = (cur.mult >= max_mult) ? max_mult : cur.mult + 3'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// paddle_ctrl_if: raster position, user inputs and paddle outputs.
//   master: timing/input side (drives coordinates, mode, buttons, accel)
//   slave : paddle_ctrl (drives obj_h, obj_v, obj_draw, moving, mult)
interface paddle_ctrl_if;
    import paddle_pkg::*;

    logic [10:0]       h_coord;
    logic [9:0]        v_coord;
    mode_t             mode;
    logic              button_l;
    logic              button_r;
    logic              button_u;
    logic              button_d;
    logic signed [7:0] accel_x;
    logic signed [7:0] accel_y;
    logic [10:0]       obj_h;
    logic [9:0]        obj_v;
    logic              obj_draw;
    logic              moving;
    logic [2:0]        mult;

    modport master (
        output h_coord, v_coord, mode, button_l, button_r, button_u, button_d, accel_x, accel_y,
        input  obj_h, obj_v, obj_draw, moving, mult
    );

    modport slave (
        input  h_coord, v_coord, mode, button_l, button_r, button_u, button_d, accel_x, accel_y,
        output obj_h, obj_v, obj_draw, moving, mult
    );

endinterface

// File: rtl/paddle_ctrl_frame_tick_gen.sv
// frame_tick_gen: end-of-frame pulse and action tick divider.
//   pixel_clk, rst_n (sync, active low)
//   h_coord, v_coord : current raster position
//   eof    : one-cycle pulse the cycle after the last active pixel
//   action : eof pulses where the frame divider is at 0
module frame_tick_gen #(
    parameter int H_RES             = 800,
    parameter int V_RES             = 600,
    parameter int FRAMES_PER_ACTION = 2
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [10:0] h_coord,
    input  logic [9:0]  v_coord,
    output logic        eof,
    output logic        action
);
    localparam int DIV_W = (FRAMES_PER_ACTION > 1) ? $clog2(FRAMES_PER_ACTION) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_ACTION - 1);

    logic             eof_q, eof_d;
    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        eof_d = (h_coord == 11'(H_RES - 1)) && (v_coord == 10'(V_RES - 1));
        div_d = div_q;
        if (eof_q) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            eof_q <= 1'b0;
            div_q <= '0;
        end else begin
            eof_q <= eof_d;
            div_q <= div_d;
        end
    end

    assign eof    = eof_q;
    assign action = eof_q && (div_q == '0);

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: moves one rectangular paddle per action tick with a speed
// ramp, clamps it to the raster and flags pixels inside it.
//   pixel_clk, rst_n (sync, active low)
//   bus (paddle_ctrl_if.slave): coordinates, mode, buttons, accel in;
//                               obj_h, obj_v, obj_draw, moving, mult out
// Build option: PADDLE_VERTICAL_EN enables vertical motion; without it
// obj_v stays at INIT_V and u/d buttons and accel_x are ignored.
//
// Ramp FSM, one per axis:
//   state     | meaning
//   RAMP_IDLE | no direction at the last action, mult = 1
//   RAMP_NEG  | moving toward 0, mult grows each action up to MAX_MULT
//   RAMP_POS  | moving toward the far edge, mult grows likewise
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int H_RES             = 800,
    parameter int V_RES             = 600,
    parameter int OBJ_W             = 100,
    parameter int OBJ_H             = 10,
    parameter int INIT_H            = 350,
    parameter int INIT_V            = 500,
    parameter int BASE_SPEED        = 5,
    parameter int MAX_MULT          = 4,
    parameter int FRAMES_PER_ACTION = 2,
    parameter int ACCEL_DEADZONE    = 2
) (
    input logic          pixel_clk,
    input logic          rst_n,
    paddle_ctrl_if.slave bus
);
    localparam logic [10:0]       H_RES_W  = 11'(H_RES);
    localparam logic [10:0]       OBJ_W_W  = 11'(OBJ_W);
    localparam logic [10:0]       SPEED_W  = 11'(BASE_SPEED);
    localparam logic [2:0]        MULT_MAX = 3'(MAX_MULT);
    localparam logic signed [7:0] DZ_POS   = 8'(ACCEL_DEADZONE);
    localparam logic signed [7:0] DZ_NEG   = -DZ_POS;

    // eof is consumed by the SVGA top level; the paddle only needs action.
    logic eof_unused;
    logic action;

    frame_tick_gen #(
        .H_RES            (H_RES),
        .V_RES            (V_RES),
        .FRAMES_PER_ACTION(FRAMES_PER_ACTION)
    ) u_tick (
        .pixel_clk(pixel_clk),
        .rst_n    (rst_n),
        .h_coord  (bus.h_coord),
        .v_coord  (bus.v_coord),
        .eof      (eof_unused),
        .action   (action)
    );

    mode_t       mode_q, mode_d;
    ramp_t       ramp_h_q, ramp_h_d;
    logic [10:0] obj_h_q, obj_h_d;
    logic        moving_q, moving_d;
    logic [10:0] step_h;
    logic        clear;
    dir_t        dir_h;
    logic [9:0]  obj_v;

`ifdef PADDLE_VERTICAL_EN
    localparam logic [10:0] V_RES_W = 11'(V_RES);
    localparam logic [10:0] OBJ_H_W = 11'(OBJ_H);
    ramp_t       ramp_v_q, ramp_v_d;
    logic [9:0]  obj_v_q, obj_v_d;
    logic [10:0] step_v;
    dir_t        dir_v;
`endif

    // Direction decode; only consumed when action is high.
    always_comb begin
        dir_h = DIR_NONE;
`ifdef PADDLE_VERTICAL_EN
        dir_v = DIR_NONE;
`endif
        case (bus.mode)
            MODE_BUTTONS: begin
                if (bus.button_l && !bus.button_r)      dir_h = DIR_NEG;
                else if (bus.button_r && !bus.button_l) dir_h = DIR_POS;
`ifdef PADDLE_VERTICAL_EN
                if (bus.button_u && !bus.button_d)      dir_v = DIR_NEG;
                else if (bus.button_d && !bus.button_u) dir_v = DIR_POS;
`endif
            end
            MODE_ACCEL: begin
                // Tilting along y moves horizontally, with inverted sense.
                if (bus.accel_y > DZ_POS)      dir_h = DIR_NEG;
                else if (bus.accel_y < DZ_NEG) dir_h = DIR_POS;
`ifdef PADDLE_VERTICAL_EN
                if (bus.accel_x < DZ_NEG)      dir_v = DIR_NEG;
                else if (bus.accel_x > DZ_POS) dir_v = DIR_POS;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        ramp_h_d = ramp_h_q;
        obj_h_d  = obj_h_q;
        moving_d = moving_q;
        step_h   = '0;
        clear    = 1'b0;
`ifdef PADDLE_VERTICAL_EN
        ramp_v_d = ramp_v_q;
        obj_v_d  = obj_v_q;
        step_v   = '0;
`endif
        if (action) begin
            clear    = (bus.mode != mode_q);
            mode_d   = bus.mode;
            // The step uses the multiplier after this action's update.
            ramp_h_d = ramp_update(ramp_h_q, dir_h, clear, MULT_MAX);
            step_h   = SPEED_W * {8'd0, ramp_h_d.mult};
            obj_h_d  = clamp_step(dir_h, obj_h_q, step_h, OBJ_W_W, H_RES_W);
            moving_d = (obj_h_d != obj_h_q);
`ifdef PADDLE_VERTICAL_EN
            ramp_v_d = ramp_update(ramp_v_q, dir_v, clear, MULT_MAX);
            step_v   = SPEED_W * {8'd0, ramp_v_d.mult};
            obj_v_d  = 10'(clamp_step(dir_v, {1'b0, obj_v_q}, step_v, OBJ_H_W, V_RES_W));
            moving_d = moving_d || (obj_v_d != obj_v_q);
`endif
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            mode_q   <= MODE_FROZEN;
            ramp_h_q <= RAMP_RST;
            obj_h_q  <= 11'(INIT_H);
            moving_q <= 1'b0;
`ifdef PADDLE_VERTICAL_EN
            ramp_v_q <= RAMP_RST;
            obj_v_q  <= 10'(INIT_V);
`endif
        end else begin
            mode_q   <= mode_d;
            ramp_h_q <= ramp_h_d;
            obj_h_q  <= obj_h_d;
            moving_q <= moving_d;
`ifdef PADDLE_VERTICAL_EN
            ramp_v_q <= ramp_v_d;
            obj_v_q  <= obj_v_d;
`endif
        end
    end

`ifdef PADDLE_VERTICAL_EN
    assign obj_v = obj_v_q;
`else
    assign obj_v = 10'(INIT_V);
`endif

    // Half-open box test, widened so obj+size cannot wrap.
    logic [11:0] h_end, v_end;
    assign h_end = {1'b0, obj_h_q} + 12'(OBJ_W);
    assign v_end = {2'b00, obj_v} + 12'(OBJ_H);

    assign bus.obj_draw = (bus.h_coord >= obj_h_q) && ({1'b0, bus.h_coord} < h_end) &&
                          (bus.v_coord >= obj_v)   && ({2'b00, bus.v_coord} < v_end);
    assign bus.obj_h    = obj_h_q;
    assign bus.obj_v    = obj_v;
    assign bus.moving   = moving_q;
    assign bus.mult     = ramp_h_q.mult;

endmodule

// File: tb/tb_paddle_ctrl.sv
module tb_paddle_ctrl;
    import paddle_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    paddle_ctrl_if bus ();
    paddle_ctrl_if bus3 ();

    paddle_ctrl dut (.pixel_clk(clk), .rst_n(rst_n), .bus(bus));
    paddle_ctrl #(.FRAMES_PER_ACTION(3)) dut3 (.pixel_clk(clk), .rst_n(rst_n), .bus(bus3));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int h;
        int v;
        int m;
        int mv;
    } exp_t;
    exp_t sb[$];

    // Reference model state (default parameters: 800x600, 100x10, speed 5, max 4, dz 2)
    int    m_h, m_v, m_mh, m_mv, m_rh, m_rv, m_moving;
    mode_t m_mode;

    task automatic model_reset();
        m_h = 350; m_v = 500; m_mh = 1; m_mv = 1; m_rh = 0; m_rv = 0; m_moving = 0;
        m_mode = MODE_FROZEN;
    endtask

    task automatic model_ramp(inout int r, inout int m, input int d);
        if (d == 0) begin
            r = 0; m = 1;
        end else if (r == d) begin
            m = (m < 4) ? m + 1 : 4;
        end else begin
            r = d; m = 1;
        end
    endtask

    function automatic int model_move(input int c, input int d, input int step, input int size,
                                      input int res);
        if (d < 0) return (c < step) ? 0 : c - step;
        if (d > 0) return (c + step + size > res - 1) ? res - 1 - size : c + step;
        return c;
    endfunction

    task automatic model_action();
        int   dh, dv, nh, nv;
        exp_t e;
        dh = 0; dv = 0;
        if (bus.mode == MODE_BUTTONS) begin
            dh = int'(bus.button_r) - int'(bus.button_l);
            dv = int'(bus.button_d) - int'(bus.button_u);
        end else if (bus.mode == MODE_ACCEL) begin
            dh = (bus.accel_y > 2) ? -1 : ((bus.accel_y < -2) ? 1 : 0);
            dv = (bus.accel_x < -2) ? -1 : ((bus.accel_x > 2) ? 1 : 0);
        end
`ifndef PADDLE_VERTICAL_EN
        dv = 0;
`endif
        if (bus.mode != m_mode) begin
            m_rh = 0; m_rv = 0;
        end
        m_mode = bus.mode;
        model_ramp(m_rh, m_mh, dh);
        model_ramp(m_rv, m_mv, dv);
        nh = model_move(m_h, dh, 5 * m_mh, 100, 800);
        nv = model_move(m_v, dv, 5 * m_mv, 10, 600);
        m_moving = (nh != m_h || nv != m_v) ? 1 : 0;
        m_h = nh; m_v = nv;
        e.h = m_h; e.v = m_v; e.m = m_mh; e.mv = m_moving;
        sb.push_back(e);
    endtask

    task automatic pulse_eof(input bit use3);
        @(negedge clk);
        if (use3) begin bus3.h_coord = 11'd799; bus3.v_coord = 10'd599; end
        else      begin bus.h_coord  = 11'd799; bus.v_coord  = 10'd599; end
        @(negedge clk);
        if (use3) begin bus3.h_coord = 11'd0; bus3.v_coord = 10'd0; end
        else      begin bus.h_coord  = 11'd0; bus.v_coord  = 10'd0; end
        @(negedge clk);
    endtask

    // One action eof (scoreboarded) followed by one non-action eof.
    task automatic do_action();
        exp_t e;
        model_action();
        pulse_eof(1'b0);
        e = sb.pop_front();
        n_checks++;
        if (bus.obj_h !== 11'(e.h)) begin
            n_fail++; $display("FAIL sb_obj_h: got %0d expected %0d", bus.obj_h, e.h);
        end
        n_checks++;
        if (bus.obj_v !== 10'(e.v)) begin
            n_fail++; $display("FAIL sb_obj_v: got %0d expected %0d", bus.obj_v, e.v);
        end
        n_checks++;
        if (bus.mult !== 3'(e.m)) begin
            n_fail++; $display("FAIL sb_mult: got %0d expected %0d", bus.mult, e.m);
        end
        n_checks++;
        if (bus.moving !== 1'(e.mv)) begin
            n_fail++; $display("FAIL sb_moving: got %0b expected %0d", bus.moving, e.mv);
        end
        pulse_eof(1'b0);
        n_checks++;
        if (bus.obj_h !== 11'(e.h)) begin
            n_fail++; $display("FAIL idle_eof_obj_h: got %0d expected %0d", bus.obj_h, e.h);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.obj_h !== 11'd350) begin n_fail++; $display("FAIL reset_obj_h: got %0d expected 350", bus.obj_h); end
        n_checks++;
        if (bus.obj_v !== 10'd500) begin n_fail++; $display("FAIL reset_obj_v: got %0d expected 500", bus.obj_v); end
        n_checks++;
        if (bus.mult !== 3'd1) begin n_fail++; $display("FAIL reset_mult: got %0d expected 1", bus.mult); end
        n_checks++;
        if (bus.moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %0b expected 0", bus.moving); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_left_ramp();
        int exp_h[5] = '{345, 335, 320, 300, 280};
        int exp_m[5] = '{1, 2, 3, 4, 4};
        bus.button_l = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_action();
            n_checks++;
            if (bus.obj_h !== 11'(exp_h[i])) begin
                n_fail++; $display("FAIL left_ramp_h[%0d]: got %0d expected %0d", i, bus.obj_h, exp_h[i]);
            end
            n_checks++;
            if (bus.mult !== 3'(exp_m[i])) begin
                n_fail++; $display("FAIL left_ramp_mult[%0d]: got %0d expected %0d", i, bus.mult, exp_m[i]);
            end
        end
        bus.button_l = 1'b0;
    endtask

    task automatic test_release_repress();
        do_action();
        n_checks++;
        if (bus.mult !== 3'd1 || bus.moving !== 1'b0 || bus.obj_h !== 11'd280) begin
            n_fail++; $display("FAIL release: got h=%0d mult=%0d moving=%0b expected 280/1/0",
                               bus.obj_h, bus.mult, bus.moving);
        end
        bus.button_r = 1'b1;
        do_action();
        n_checks++;
        if (bus.obj_h !== 11'd285 || bus.mult !== 3'd1) begin
            n_fail++; $display("FAIL repress_first: got h=%0d mult=%0d expected 285/1", bus.obj_h, bus.mult);
        end
        do_action();
        n_checks++;
        if (bus.obj_h !== 11'd295 || bus.mult !== 3'd2) begin
            n_fail++; $display("FAIL repress_second: got h=%0d mult=%0d expected 295/2", bus.obj_h, bus.mult);
        end
        bus.button_r = 1'b0;
    endtask

    task automatic test_both_buttons();
        apply_reset();
        bus.button_l = 1'b1;
        bus.button_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_action();
            n_checks++;
            if (bus.obj_h !== 11'd350 || bus.mult !== 3'd1) begin
                n_fail++; $display("FAIL both_buttons[%0d]: got h=%0d mult=%0d expected 350/1", i, bus.obj_h, bus.mult);
            end
        end
        bus.button_l = 1'b0;
        bus.button_r = 1'b0;
    endtask

    task automatic test_right_clamp();
        int n;
        bus.button_l = 1'b1;
        n = 0;
        while (m_h != 0 && n < 40) begin do_action(); n++; end
        bus.button_l = 1'b0;
        n_checks++;
        if (bus.obj_h !== 11'd0) begin n_fail++; $display("FAIL left_edge: got %0d expected 0", bus.obj_h); end
        bus.button_r = 1'b1;
        n = 0;
        while (m_h != 690 && n < 60) begin do_action(); n++; end
        bus.button_r = 1'b0;
        n_checks++;
        if (bus.obj_h !== 11'd690) begin n_fail++; $display("FAIL reach_690: got %0d expected 690", bus.obj_h); end
        do_action();
        bus.button_r = 1'b1;
        do_action();
        n_checks++;
        if (bus.obj_h !== 11'd695 || bus.moving !== 1'b1) begin
            n_fail++; $display("FAIL clamp_first: got h=%0d moving=%0b expected 695/1", bus.obj_h, bus.moving);
        end
        do_action();
        n_checks++;
        if (bus.obj_h !== 11'd699 || bus.mult !== 3'd2) begin
            n_fail++; $display("FAIL clamp_second: got h=%0d mult=%0d expected 699/2", bus.obj_h, bus.mult);
        end
        do_action();
        n_checks++;
        if (bus.obj_h !== 11'd699 || bus.moving !== 1'b0) begin
            n_fail++; $display("FAIL clamp_hold: got h=%0d moving=%0b expected 699/0", bus.obj_h, bus.moving);
        end
        bus.button_r = 1'b0;
    endtask

    task automatic test_frozen();
        bus.mode     = mode_t'(2'b01);
        bus.button_l = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_action();
            n_checks++;
            if (bus.obj_h !== 11'd699 || bus.mult !== 3'd1 || bus.moving !== 1'b0) begin
                n_fail++; $display("FAIL frozen[%0d]: got h=%0d mult=%0d moving=%0b expected 699/1/0",
                                   i, bus.obj_h, bus.mult, bus.moving);
            end
        end
        bus.button_l = 1'b0;
    endtask

    task automatic test_accel();
        bus.mode    = MODE_ACCEL;
        bus.accel_y = 8'sd2;
        bus.accel_x = 8'sd2;
        for (int i = 0; i < 2; i++) begin
            do_action();
            n_checks++;
            if (bus.obj_h !== 11'd699 || bus.moving !== 1'b0) begin
                n_fail++; $display("FAIL accel_deadzone[%0d]: got h=%0d moving=%0b expected 699/0", i, bus.obj_h, bus.moving);
            end
        end
        bus.accel_y = 8'sd3;
        bus.accel_x = -8'sd3;
        do_action();
        n_checks++;
        if (bus.obj_h !== 11'd694) begin n_fail++; $display("FAIL accel_h1: got %0d expected 694", bus.obj_h); end
        do_action();
        n_checks++;
        if (bus.obj_h !== 11'd684) begin n_fail++; $display("FAIL accel_h2: got %0d expected 684", bus.obj_h); end
        n_checks++;
`ifdef PADDLE_VERTICAL_EN
        if (bus.obj_v !== 10'd485) begin n_fail++; $display("FAIL accel_v: got %0d expected 485", bus.obj_v); end
`else
        if (bus.obj_v !== 10'd500) begin n_fail++; $display("FAIL accel_v: got %0d expected 500", bus.obj_v); end
`endif
        bus.accel_y = -8'sd3;
        do_action();
        n_checks++;
        if (bus.obj_h !== 11'd689 || bus.mult !== 3'd1) begin
            n_fail++; $display("FAIL accel_reverse: got h=%0d mult=%0d expected 689/1", bus.obj_h, bus.mult);
        end
        bus.accel_y = 8'sd0;
        bus.accel_x = 8'sd0;
        bus.mode    = MODE_BUTTONS;
    endtask

    task automatic test_obj_draw();
        int dh[6] = '{0, -1, 99, 100, 0, 50};
        int dv[6] = '{0, 0, 9, 0, 10, -1};
        bit ex[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.h_coord = 11'(m_h + dh[i]);
            bus.v_coord = 10'(m_v + dv[i]);
            #1;
            n_checks++;
            if (bus.obj_draw !== ex[i]) begin
                n_fail++; $display("FAIL obj_draw[%0d]: got %0b expected %0b at (%0d,%0d)",
                                   i, bus.obj_draw, ex[i], bus.h_coord, bus.v_coord);
            end
        end
        @(negedge clk);
        bus.h_coord = 11'd0;
        bus.v_coord = 10'd0;
    endtask

    task automatic test_mid_reset();
        bus.button_r = 1'b1;
        pulse_eof(1'b0);
        n_checks++;
        if (bus.obj_h !== 11'd694) begin n_fail++; $display("FAIL pre_reset_move: got %0d expected 694", bus.obj_h); end
        bus.button_r = 1'b0;
        @(negedge clk);
        bus.h_coord = 11'd400;
        bus.v_coord = 10'd300;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.obj_h !== 11'd350 || bus.obj_v !== 10'd500 || bus.mult !== 3'd1 || bus.moving !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got h=%0d v=%0d mult=%0d moving=%0b expected 350/500/1/0",
                               bus.obj_h, bus.obj_v, bus.mult, bus.moving);
        end
        rst_n = 1'b1;
        model_reset();
        bus.button_l = 1'b1;
        pulse_eof(1'b0);
        n_checks++;
        if (bus.obj_h !== 11'd345) begin n_fail++; $display("FAIL post_reset_action: got %0d expected 345", bus.obj_h); end
        pulse_eof(1'b0);
        n_checks++;
        if (bus.obj_h !== 11'd345) begin n_fail++; $display("FAIL post_reset_idle: got %0d expected 345", bus.obj_h); end
        bus.button_l = 1'b0;
    endtask

    task automatic test_fpa3();
        int exp_h[7] = '{345, 345, 345, 335, 335, 335, 320};
        apply_reset();
        bus3.mode     = MODE_BUTTONS;
        bus3.button_l = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pulse_eof(1'b1);
            n_checks++;
            if (bus3.obj_h !== 11'(exp_h[i])) begin
                n_fail++; $display("FAIL fpa3_h[%0d]: got %0d expected %0d", i, bus3.obj_h, exp_h[i]);
            end
        end
        n_checks++;
        if (bus3.mult !== 3'd3) begin n_fail++; $display("FAIL fpa3_mult: got %0d expected 3", bus3.mult); end
        bus3.button_l = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.h_coord = 11'd0;  bus.v_coord = 10'd0;  bus.mode = MODE_BUTTONS;
        bus.button_l = 1'b0;  bus.button_r = 1'b0;  bus.button_u = 1'b0; bus.button_d = 1'b0;
        bus.accel_x = 8'sd0;  bus.accel_y = 8'sd0;
        bus3.h_coord = 11'd0; bus3.v_coord = 10'd0; bus3.mode = MODE_BUTTONS;
        bus3.button_l = 1'b0; bus3.button_r = 1'b0; bus3.button_u = 1'b0; bus3.button_d = 1'b0;
        bus3.accel_x = 8'sd0; bus3.accel_y = 8'sd0;
        model_reset();

        test_reset();
        test_left_ramp();
        test_release_repress();
        test_both_buttons();
        test_right_clamp();
        test_frozen();
        test_accel();
        test_obj_draw();
        test_mid_reset();
        test_fpa3();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
